alu_uart_bridge: RTL and testbench
==================================

# alu_uart_bridge

Parametrised command bridge between the UART receiver/transmitter pair and the ALU. It decodes byte-wide commands, assembles multi-byte operands, and streams multi-byte results back through the transmitter with a proper done handshake. It also detects rx timeouts, bad opcodes and overruns, and reports them through a status command. It replaces the single-byte, fire-and-forget ALU interface.

## Interface
- NB_DATA, 16: ALU operand/result width; multiple of 8, ≥8; NBYTES = NB_DATA/8.
- NB_ALU_OP, 6: ALU opcode width, ≤8.
- NB_TIMEOUT, 16: timeout counter width.
- TIMEOUT_CYCLES, 50000: idle cycles allowed between bytes of one command; must fit NB_TIMEOUT.
- i_clk  in  1  system clock; all logic rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte, valid when i_rx_done.
- i_rx_done  in  1  one-cycle pulse per received byte.
- i_tx_done  in  1  one-cycle pulse when transmitter finishes a byte.
- i_alu_res  in  NB_DATA  ALU result.
- o_tx_start  out  1  one-cycle pulse, launches o_tx_data.
- o_tx_data  out  8  byte to transmit, stable until i_tx_done.
- o_alu_op  out  NB_ALU_OP  ALU opcode register.
- o_alu_a  out  NB_DATA  operand A register.
- o_alu_b  out  NB_DATA  operand B register.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_err  out  1  OR of sticky error flags.

## Operation
- Commands (first byte): 0x00 GET_RES, 0x01 SET_A, 0x02 SET_B, 0x03 SET_OP, 0x04 GET_STATUS; any other byte is an unknown opcode.
- States: IDLE, RECV, SEND, WAIT.
- IDLE, on i_rx_done:
  - SET_A/SET_B: RECV, byte counter = 0.
  - SET_OP: RECV, expecting 1 byte.
  - GET_RES: snapshot i_alu_res into tx shift register, go to SEND.
  - GET_STATUS: load status byte {5'b0, err_overrun, err_timeout, err_opcode}, clear all three flags, go to SEND with 1 byte.
  - Unknown opcode: set err_opcode, stay in IDLE.
- RECV:
  - Each i_rx_done shifts a byte into a shadow register, LSB byte first.
  - On the last byte (NBYTES for A/B, 1 for OP), commit the shadow to o_alu_a / o_alu_b / o_alu_op (OP takes the low NB_ALU_OP bits), then go to IDLE.
  - Partial operands are never visible on the outputs.
- RECV timeout:
  - Counter clears on entry and on every accepted byte, and increments otherwise.
  - At TIMEOUT_CYCLES: set err_timeout, discard the shadow, go to IDLE; target register is unchanged.
- SEND: assert o_tx_start for one cycle with the current byte (LSB first), then go to WAIT.
- WAIT:
  - On i_tx_done: if more bytes remain, shift and return to SEND; otherwise go to IDLE.
  - No timeout in WAIT.
- i_rx_done while in SEND or WAIT: byte dropped, err_overrun set.
- Simultaneous i_rx_done and timeout expiry in RECV: the byte wins and the counter clears.
- Error flags are sticky until a GET_STATUS read or reset. If an error event coincides with the clear, the flag ends set.

## Timing
- Reset (async assert, sync-free release):
  - State IDLE.
  - o_tx_start = 0, o_tx_data = 0x00.
  - o_alu_a = o_alu_b = 0, o_alu_op = 0.
  - o_busy = 0, all flags 0, counters 0.
- Reset asserted mid-command or mid-transmission aborts immediately; no further tx_start pulses.
- Command byte: i_rx_done in cycle N gives the new state and o_busy = 1 in cycle N+1.
- Operand commit: i_rx_done of the last byte in cycle N gives o_alu_x updated and o_busy = 0 in cycle N+1.
- GET_RES / GET_STATUS:
  - i_rx_done in cycle N: i_alu_res is sampled at the end of cycle N.
  - o_tx_start is high in cycle N+1 with byte 0 on o_tx_data.
  - i_tx_done in cycle M gives o_tx_start high in cycle M+1 with the next byte, or IDLE in M+1 after the last byte.
- o_tx_data holds its value between bytes and after completion.
- Timeout: the TIMEOUT_CYCLES-th consecutive cycle in RECV without i_rx_done ends with the state IDLE and o_err = 1 on the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Operand load (NB_DATA=16): send 0x01,0x34,0x12 then 0x02,0xCD,0xAB then 0x03,0x20.
  - o_alu_a = 0x1234, o_alu_b = 0xABCD, o_alu_op = 0x20, each one cycle after its last byte.
  - o_alu_a stays 0 after 0x34 alone.
- Result read: i_alu_res = 0xBEEF, send 0x00.
  - tx_start with 0xEF one cycle later; no second pulse until i_tx_done.
  - Then tx_start with 0xBE.
  - i_alu_res changing mid-transfer does not alter the bytes.
- Timeout (TIMEOUT_CYCLES=100): send 0x01,0x55 and then nothing.
  - IDLE and o_err = 1 after 100 cycles, o_alu_a unchanged.
  - A following 0x04 transmits 0x02, after which o_err = 0.
- Errors: send 0x7F, then a byte during WAIT.
  - 0x04 transmits 0x05.
  - A second 0x04 transmits 0x00.
- Reset mid-RECV and mid-WAIT (async, not clock-aligned): outputs return to their reset values immediately, and a subsequent full command works normally.

Source files
------------

// File: rtl/alu_uart_bridge.sv
// Command bridge between a byte-wide UART rx/tx pair and the ALU operand/opcode registers.
// Assembles multi-byte operands, streams results LSB first and reports sticky error flags.
module alu_uart_bridge #(
  parameter int NB_DATA        = 16,
  parameter int NB_ALU_OP      = 6,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_res,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic [NB_ALU_OP-1:0] o_alu_op,
  output logic [NB_DATA-1:0]   o_alu_a,
  output logic [NB_DATA-1:0]   o_alu_b,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int NBYTES = NB_DATA / 8;
  localparam int NB_CNT = $clog2(NBYTES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam logic [1:0] TGT_A  = 2'd0;
  localparam logic [1:0] TGT_B  = 2'd1;
  localparam logic [1:0] TGT_OP = 2'd2;

  localparam logic [7:0] CMD_GET_RES    = 8'h00;
  localparam logic [7:0] CMD_SET_A      = 8'h01;
  localparam logic [7:0] CMD_SET_B      = 8'h02;
  localparam logic [7:0] CMD_SET_OP     = 8'h03;
  localparam logic [7:0] CMD_GET_STATUS = 8'h04;

  logic [1:0]           state_q, state_d;
  logic [1:0]           tgt_q, tgt_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  logic [NB_CNT-1:0]    left_q, left_d;
  logic [NB_DATA-1:0]   shadow_q, shadow_d;
  logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
  logic [NB_DATA-1:0]   tx_sh_q, tx_sh_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
  logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
  logic [NB_ALU_OP-1:0] alu_op_q, alu_op_d;
  logic                 err_op_q, err_op_d;
  logic                 err_tmo_q, err_tmo_d;
  logic                 err_ovr_q, err_ovr_d;
  logic                 busy_q, err_q;
  logic                 set_op, set_tmo, set_ovr, clr_err, last_byte;
  logic [7:0]           status;

  assign status = {5'b0, err_ovr_q, err_tmo_q, err_op_q};

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    shadow_d   = shadow_q;
    tmo_d      = tmo_q;
    tx_sh_d    = tx_sh_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    set_op     = 1'b0;
    set_tmo    = 1'b0;
    set_ovr    = 1'b0;
    clr_err    = 1'b0;
    last_byte  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_SET_A, CMD_SET_B, CMD_SET_OP: begin
              state_d  = ST_RECV;
              tgt_d    = (i_rx_data == CMD_SET_A) ? TGT_A :
                         (i_rx_data == CMD_SET_B) ? TGT_B : TGT_OP;
              cnt_d    = '0;
              tmo_d    = '0;
              shadow_d = '0;
            end
            // tx_start is raised on the transition so byte 0 leaves in the first SEND cycle
            CMD_GET_RES: begin
              state_d    = ST_SEND;
              tx_sh_d    = i_alu_res;
              left_d     = NB_CNT'(NBYTES);
              tx_start_d = 1'b1;
              tx_data_d  = i_alu_res[7:0];
            end
            CMD_GET_STATUS: begin
              state_d    = ST_SEND;
              tx_sh_d    = NB_DATA'(status);
              left_d     = NB_CNT'(1);
              tx_start_d = 1'b1;
              tx_data_d  = status;
              clr_err    = 1'b1;
            end
            default: set_op = 1'b1;
          endcase
        end
      end
      ST_RECV: begin
        if (i_rx_done) begin
          tmo_d = '0;
          for (int k = 0; k < NBYTES; k++) begin
            if (cnt_q == NB_CNT'(k)) shadow_d[8*k +: 8] = i_rx_data;
          end
          last_byte = (tgt_q == TGT_OP) || (cnt_q == NB_CNT'(NBYTES - 1));
          if (last_byte) begin
            state_d = ST_IDLE;
            case (tgt_q)
              TGT_A:   alu_a_d  = shadow_d;
              TGT_B:   alu_b_d  = shadow_d;
              default: alu_op_d = i_rx_data[NB_ALU_OP-1:0];
            endcase
          end else begin
            cnt_d = cnt_q + NB_CNT'(1);
          end
        end else if (tmo_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
          set_tmo  = 1'b1;
          shadow_d = '0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + NB_TIMEOUT'(1);
        end
      end
      ST_SEND: begin
        set_ovr = i_rx_done;
        state_d = ST_WAIT;
      end
      default: begin
        set_ovr = i_rx_done;
        if (i_tx_done) begin
          if (left_q > NB_CNT'(1)) begin
            left_d     = left_q - NB_CNT'(1);
            tx_sh_d    = tx_sh_q >> 8;
            tx_data_d  = tx_sh_d[7:0];
            tx_start_d = 1'b1;
            state_d    = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
    // an event coinciding with the status-read clear leaves its flag set
    err_op_d  = (err_op_q  & ~clr_err) | set_op;
    err_tmo_d = (err_tmo_q & ~clr_err) | set_tmo;
    err_ovr_d = (err_ovr_q & ~clr_err) | set_ovr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tgt_q      <= TGT_A;
      cnt_q      <= '0;
      left_q     <= '0;
      shadow_q   <= '0;
      tmo_q      <= '0;
      tx_sh_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      err_op_q   <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      shadow_q   <= shadow_d;
      tmo_q      <= tmo_d;
      tx_sh_q    <= tx_sh_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      err_op_q   <= err_op_d;
      err_tmo_q  <= err_tmo_d;
      err_ovr_q  <= err_ovr_d;
      busy_q     <= (state_d != ST_IDLE);
      err_q      <= err_op_d | err_tmo_d | err_ovr_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_alu_uart_bridge.sv
// Scoreboard bench for alu_uart_bridge: directed scenarios plus randomized commands
// against a command-level reference model; a monitor checks every transmitted byte.
module tb_alu_uart_bridge;
  localparam int NB_DATA = 16;
  localparam int NB_ALU_OP = 6;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic [15:0] alu_res;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [5:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        busy, err;

  always #5 clk = ~clk;

  alu_uart_bridge #(.NB_DATA(NB_DATA), .NB_ALU_OP(NB_ALU_OP), .NB_TIMEOUT(16),
                    .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_res(alu_res), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_busy(busy), .o_err(err));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int tx_delay = 2;
  bit abort = 1'b0;

  // reference model: register contents and error flags as seen by the host
  logic [15:0] m_a, m_b;
  logic [5:0]  m_op;
  bit m_eop, m_etmo, m_eovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0;
    m_eop = 0; m_etmo = 0; m_eovr = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_a"}, alu_a, m_a);
    check({tag, "_b"}, alu_b, m_b);
    check({tag, "_op"}, alu_op, m_op);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 400) begin tick(1); k++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic set_operand(input logic [7:0] cmd, input logic [15:0] v);
    send_byte(cmd);
    check("cmd_busy", busy, 1);
    tick($urandom_range(0, 4));
    send_byte(v[7:0]);
    check_regs("partial");
    tick($urandom_range(0, 4));
    send_byte(v[15:8]);
    if (cmd == 8'h01) m_a = v; else m_b = v;
    check_regs("commit");
    check("commit_busy", busy, 0);
  endtask

  task automatic set_op(input logic [7:0] v);
    send_byte(8'h03);
    check("op_busy", busy, 1);
    tick($urandom_range(0, 4));
    send_byte(v);
    m_op = v[5:0];
    check_regs("op_commit");
    check("op_commit_busy", busy, 0);
  endtask

  task automatic get_res(input logic [15:0] v);
    alu_res = v;
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
    send_byte(8'h00);
    check("res_first_start", tx_start, 1);
    check("res_first_byte", tx_data, v[7:0]);
    alu_res = 16'($urandom);
    wait_idle("res");
  endtask

  task automatic get_status();
    exp_q.push_back({5'b0, m_eovr, m_etmo, m_eop});
    m_eop = 0; m_etmo = 0; m_eovr = 0;
    send_byte(8'h04);
    wait_idle("status");
    check("status_err_clear", err, 0);
  endtask

  task automatic bad_op(input logic [7:0] b);
    send_byte(b);
    m_eop = 1;
    check("badop_busy", busy, 0);
    check("badop_err", err, 1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    abort = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_op", alu_op, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    tick(12);
    abort = 1'b0;
  endtask

  // monitor and transmitter model: pops expected bytes, answers each launch with tx_done
  initial begin
    logic [7:0] e;
    bit have;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      while (tx_start) begin
        have = (exp_q.size() != 0);
        check("tx_start_expected", have, 1);
        e = have ? exp_q.pop_front() : 8'h00;
        if (have) check("tx_byte", tx_data, e);
        for (int i = 0; i < tx_delay; i++) begin
          @(negedge clk);
          if (abort) break;
          check("tx_single_pulse", tx_start, 0);
          if (have) check("tx_hold", tx_data, e);
        end
        if (abort) break;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; alu_res = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_tx_data", tx_data, 0);
    check_regs("reset");
    #3 rst = 1'b0;
    @(posedge clk); #1;

    set_operand(8'h01, 16'h1234);
    check("dir_a", alu_a, 16'h1234);
    set_operand(8'h02, 16'hABCD);
    check("dir_b", alu_b, 16'hABCD);
    set_op(8'h20);
    check("dir_op", alu_op, 6'h20);

    tx_delay = 4;
    get_res(16'hBEEF);
    tx_delay = 2;

    // timeout: one operand byte, then silence
    send_byte(8'h01);
    send_byte(8'h55);
    tick(T - 1);
    check("tmo_still_busy", busy, 1);
    tick(1);
    m_etmo = 1;
    check("tmo_idle", busy, 0);
    check("tmo_err", err, 1);
    check_regs("tmo");
    get_status();

    // opcode error, then overrun during WAIT
    bad_op(8'h7F);
    tx_delay = 10;
    alu_res = 16'h9A3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h9A);
    send_byte(8'h00);
    tick(3);
    send_byte(8'h99);
    m_eovr = 1;
    wait_idle("ovr");
    tx_delay = 2;
    check("ovr_err", err, 1);
    get_status();
    get_status();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: set_operand(8'h01, 16'($urandom));
        1: set_operand(8'h02, 16'($urandom));
        2: set_op(8'($urandom));
        3: begin tx_delay = $urandom_range(1, 4); get_res(16'($urandom)); end
        4: get_status();
        default: bad_op(8'($urandom_range(5, 255)));
      endcase
      tick($urandom_range(0, 3));
      check_regs("rand");
      check("rand_err", err, 32'(m_eop | m_etmo | m_eovr));
    end
    tx_delay = 2;

    set_operand(8'h01, 16'h5AA5);
    send_byte(8'h01);
    send_byte(8'h77);
    do_reset();

    tx_delay = 10;
    alu_res = 16'hA5C3;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    send_byte(8'h00);
    tick(3);
    do_reset();
    tx_delay = 2;

    set_operand(8'h01, 16'h4321);
    get_res(16'h1357);
    check_regs("post_reset");

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
